sprite_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one synchronous sprite ROM (4-bit palette-index output) among up to NREQ sprite renderers (ducks, background, HUD). It grants at most one ROM read per vga_clk cycle, drives the ROM address, and tags each returned palette index with the winning requester's ID. It sits between the per-object sprite renderers and the shared ROM/palette pair, ahead of the pixel mux.

---
 rtl/sprite_rom_arbiter.sv | 113 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin arbiter sharing one synchronous sprite ROM among NREQ sprite
//   renderers. At most one ROM read is granted per vga_clk cycle. Each
//   returned palette index is tagged with the winning requester's ID.
//
// Ports
//   i_vga_clk      pixel clock, all state on posedge
//   i_reset        asynchronous active-high reset
//   i_frame_start  one-cycle pulse, rewinds the priority pointer to 0
//   i_req          per-requester read request (level)
//   i_addr         requester i address at [i*AW +: AW]
//   o_gnt          one-hot grant, combinational from i_req
//   o_rom_address  registered ROM address
//   i_rom_q        ROM read data, valid ROM_LAT cycles after the address
//   o_rsp_valid    one cycle per grant, ROM_LAT+1 cycles after the grant
//   o_rsp_id       requester index of the response
//   o_rsp_data     palette index; holds between responses
module sprite_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 12,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1,
  // Derived from NREQ; do not override.
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 i_vga_clk,
  input  logic                 i_reset,
  input  logic                 i_frame_start,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*AW-1:0]   i_addr,
  output logic [NREQ-1:0]      o_gnt,
  output logic [AW-1:0]        o_rom_address,
  input  logic [DW-1:0]        i_rom_q,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [DW-1:0]       o_rsp_data
);

  // Tag pipe: stage s holds the grant issued s+1 cycles ago. The last stage
  // (ROM_LAT) lines up with the cycle the response is presented.
  logic [ROM_LAT:0]            r_vld_pipe;
  logic [ROM_LAT:0][IDW-1:0]   r_id_pipe;

  logic [IDW-1:0]              r_ptr;
  logic [AW-1:0]               r_rom_address;
  logic [DW-1:0]               r_rsp_data;

  logic                        w_found;
  logic [IDW-1:0]              w_win;
  logic [AW-1:0]               w_win_addr;
  logic [IDW-1:0]              w_ptr_nxt;
  int                          w_idx;

  // Rotating priority scan starting at r_ptr. r_ptr never exceeds NREQ-1,
  // so a single subtraction folds the index back into range.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_addr = '0;
    w_idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = IDW'(w_idx);
        w_win_addr = i_addr[w_idx*AW +: AW];
      end
    end
  end

  // Explicit wrap so non-power-of-two NREQ never yields an ID >= NREQ.
  assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;

  for (genvar g = 0; g < NREQ; g++) begin : g_gnt
    assign o_gnt[g] = w_found && !i_reset && (w_win == IDW'(g));
  end

  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr         <= '0;
      r_rom_address <= '0;
    end else begin
      if (w_found) r_rom_address <= w_win_addr;
      // frame_start takes precedence over the post-grant pointer advance.
      if (i_frame_start)  r_ptr <= '0;
      else if (w_found)   r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_vld_pipe[0] <= w_found;
      r_id_pipe[0]  <= w_found ? w_win : '0;
      for (int s = 1; s <= ROM_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_id_pipe[s]  <= r_id_pipe[s-1];
      end
      // ROM data for the tag entering the last stage is valid at this edge.
      if (r_vld_pipe[ROM_LAT-1]) r_rsp_data <= i_rom_q;
    end
  end

  assign o_rom_address = r_rom_address;
  assign o_rsp_valid   = r_vld_pipe[ROM_LAT];
  assign o_rsp_id      = r_id_pipe[ROM_LAT];
  assign o_rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (NREQ=4/ROM_LAT=1 and
// NREQ=3/ROM_LAT=2) share clock, reset, frame_start and request stimulus.
// A transaction-level reference model predicts grants, ROM addresses and the
// tagged response stream, indexed by the cycle each response is due.
module tb_sprite_rom_arbiter;
  localparam int AW = 12;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fs;
  logic [3:0]    req;
  logic [AW-1:0] a [4];

  logic [4*AW-1:0] addr0;
  logic [3*AW-1:0] addr1;
  logic [3:0]      gnt0;
  logic [2:0]      gnt1;
  logic [AW-1:0]   ra0, ra1, ra1_d;
  logic [DW-1:0]   q0, q1, d0, d1;
  logic            rv0, rv1;
  logic [1:0]      id0, id1;

  assign addr0 = {a[3], a[2], a[1], a[0]};
  assign addr1 = {a[2], a[1], a[0]};

  function automatic logic [3:0] rom_fn(logic [AW-1:0] x);
    return x[3:0] + x[7:4] * 4'd3 + x[11:8] * 4'd5;
  endfunction

  // ROM models: latency 1 presents data for the current address at the
  // closing edge; latency 2 adds one register on the address.
  always_ff @(posedge clk) ra1_d <= ra1;
  always_comb q0 = rom_fn(ra0);
  always_comb q1 = rom_fn(ra1_d);

  sprite_rom_arbiter #(.NREQ(4), .AW(AW), .DW(DW), .ROM_LAT(1)) u0 (
    .i_vga_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_req(req),
    .i_addr(addr0), .o_gnt(gnt0), .o_rom_address(ra0), .i_rom_q(q0),
    .o_rsp_valid(rv0), .o_rsp_id(id0), .o_rsp_data(d0));

  sprite_rom_arbiter #(.NREQ(3), .AW(AW), .DW(DW), .ROM_LAT(2)) u1 (
    .i_vga_clk(clk), .i_reset(rst), .i_frame_start(fs), .i_req(req[2:0]),
    .i_addr(addr1), .o_gnt(gnt1), .o_rom_address(ra1), .i_rom_q(q1),
    .o_rsp_valid(rv1), .o_rsp_id(id1), .o_rsp_data(d1));

  logic [3:0]    g_o  [2];
  logic [AW-1:0] ra_o [2];
  logic          rv_o [2];
  logic [1:0]    id_o [2];
  logic [DW-1:0] d_o  [2];
  assign g_o[0] = gnt0;   assign g_o[1] = {1'b0, gnt1};
  assign ra_o[0] = ra0;   assign ra_o[1] = ra1;
  assign rv_o[0] = rv0;   assign rv_o[1] = rv1;
  assign id_o[0] = id0;   assign id_o[1] = id1;
  assign d_o[0] = d0;     assign d_o[1] = d1;

  // Reference model state
  int            NR  [2] = '{4, 3};
  int            LAT [2] = '{1, 2};
  int            m_ptr [2];
  logic [AW-1:0] m_ra  [2];
  logic [DW-1:0] m_d   [2];
  logic          sv   [2][16];
  logic [1:0]    sid  [2][16];
  logic [DW-1:0] sdat [2][16];

  int cyc, n_chk, n_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(int k);
    m_ptr[k] = 0;
    m_ra[k]  = '0;
    m_d[k]   = '0;
    for (int s = 0; s < 16; s++) sv[k][s] = 1'b0;
  endtask

  // First requester at or after the pointer, wrapping modulo NREQ.
  function automatic int winner(int k);
    for (int j = 0; j < NR[k]; j++) begin
      int i = (m_ptr[k] + j) % NR[k];
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    int w [2];
    int slot, due;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      w[k] = rst ? -1 : winner(k);
      chk($sformatf("u%0d.gnt", k), 32'(g_o[k]), (w[k] >= 0) ? (32'd1 << w[k]) : 32'd0);
      chk($sformatf("u%0d.rom_address", k), 32'(ra_o[k]), 32'(m_ra[k]));
      slot = cyc % 16;
      if (sv[k][slot]) begin
        chk($sformatf("u%0d.rsp_valid", k), 32'(rv_o[k]), 32'd1);
        chk($sformatf("u%0d.rsp_id", k), 32'(id_o[k]), 32'(sid[k][slot]));
        m_d[k] = sdat[k][slot];
        sv[k][slot] = 1'b0;
      end else begin
        chk($sformatf("u%0d.rsp_valid", k), 32'(rv_o[k]), 32'd0);
        if (rst) chk($sformatf("u%0d.rsp_id_rst", k), 32'(id_o[k]), 32'd0);
      end
      chk($sformatf("u%0d.rsp_data", k), 32'(d_o[k]), 32'(m_d[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst && w[k] >= 0) begin
        m_ra[k]  = a[w[k]];
        m_ptr[k] = (w[k] + 1) % NR[k];
        due      = (cyc + LAT[k] + 1) % 16;
        sv[k][due]   = 1'b1;
        sid[k][due]  = 2'(w[k]);
        sdat[k][due] = rom_fn(a[w[k]]);
      end
      if (!rst && fs) m_ptr[k] = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic rand_addr();
    for (int i = 0; i < 4; i++) a[i] = AW'($urandom);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; fs = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_err = 0;
    rst = 1'b1; fs = 1'b0; req = '0;
    for (int i = 0; i < 4; i++) a[i] = '0;
    for (int k = 0; k < 2; k++) model_reset(k);
    #1;
    tick(); tick();
    rst = 1'b0;

    // Single requester 2 at 0x123
    a[2] = 12'h123; req = 4'b0100;
    tick();
    req = '0;
    repeat (4) tick();

    // All requesting continuously from reset
    pulse_reset();
    req = 4'hF;
    repeat (8) begin rand_addr(); tick(); end
    req = '0;
    repeat (4) tick();

    // Sparse fairness: move ptr to 1, hold 1001, then add requester 1
    pulse_reset();
    req = 4'b0001; rand_addr(); tick();
    req = 4'b1001;
    repeat (4) begin rand_addr(); tick(); end
    req = 4'b1011;
    repeat (6) begin rand_addr(); tick(); end
    req = '0;
    repeat (4) tick();

    // frame_start while ptr=3 (4-requester instance) with all requesting
    pulse_reset();
    req = 4'hF;
    repeat (3) begin rand_addr(); tick(); end
    fs = 1'b1; rand_addr(); tick();
    fs = 1'b0;
    repeat (3) begin rand_addr(); tick(); end
    req = '0;
    repeat (2) tick();

    // Reset with two reads in flight, then a normal grant afterwards
    pulse_reset();
    req = 4'hF;
    repeat (2) begin rand_addr(); tick(); end
    rst = 1'b1; tick();
    rst = 1'b0; req = '0; tick();
    req = 4'b0010; rand_addr(); tick();
    req = '0;
    repeat (4) tick();

    // Randomized traffic with occasional frame_start and reset
    repeat (500) begin
      req = 4'($urandom);
      rand_addr();
      fs  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; fs = 1'b0; req = '0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
